// File: rtl/ctrl_program_loader.sv
// Control-program loader: streams a program into the LUD control-word SRAM, optionally
// reads it back against a shadow copy and checksum, then runs the START/COMPLETED handshake.
module ctrl_program_loader #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned CTRL_WIDTH    = 60,
  parameter int unsigned TIMEOUT_WIDTH = 24
) (
  input  logic                  CLK_100,
  input  logic                  RST,
  input  logic                  go,
  input  logic                  verify_en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CTRL_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] bram_ZYNQ_INST_addr,
  output logic [CTRL_WIDTH-1:0] bram_ZYNQ_INST_din,
  input  logic [CTRL_WIDTH-1:0] bram_ZYNQ_INST_dout,
  output logic                  bram_ZYNQ_INST_en,
  output logic                  bram_ZYNQ_INST_we,
  output logic                  START,
  input  logic                  COMPLETED,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, VERIFY, ARM, WAIT_LO, WAIT_HI, DONE, ERR
  } state_t;

  state_t                   state;
  logic                     verify_q;
  logic [CTRL_WIDTH-1:0]    csum;
  logic [CTRL_WIDTH-1:0]    rb_sum;
  logic [CNT_W-1:0]         rd_cnt;
  logic                     cmp_v;
  logic [ADDR_WIDTH-1:0]    cmp_addr;
  logic [CTRL_WIDTH-1:0]    exp_word;
  logic [TIMEOUT_WIDTH-1:0] wd;
  logic [TIMEOUT_WIDTH-1:0] wd_next;
  logic                     accept;
  logic                     last_slot;
  logic [CTRL_WIDTH-1:0]    shadow [DEPTH];

  assign accept    = s_valid & s_ready;
  assign last_slot = (word_count == CNT_W'(DEPTH - 1));
  assign wd_next   = wd + TIMEOUT_WIDTH'(1);

  // Shadow copy of the program; its registered read lines up with the SRAM read data.
  always_ff @(posedge CLK_100) begin
    if (state == LOAD && accept)
      shadow[word_count[ADDR_WIDTH-1:0]] <= s_data;
    exp_word <= shadow[bram_ZYNQ_INST_addr];
  end

  always_ff @(posedge CLK_100) begin
    if (RST) begin
      state               <= IDLE;
      s_ready             <= 1'b0;
      START               <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 3'b000;
      word_count          <= '0;
      err_addr            <= '0;
      bram_ZYNQ_INST_en   <= 1'b1;
      bram_ZYNQ_INST_we   <= 1'b1;
      bram_ZYNQ_INST_addr <= '0;
      bram_ZYNQ_INST_din  <= '0;
      verify_q            <= 1'b0;
      csum                <= '0;
      rb_sum              <= '0;
      rd_cnt              <= '0;
      cmp_v               <= 1'b0;
      cmp_addr            <= '0;
      wd                  <= '0;
    end else begin
      // Port idles unless a write or read is issued below; track reads for the compare stage.
      bram_ZYNQ_INST_en <= 1'b1;
      bram_ZYNQ_INST_we <= 1'b1;
      cmp_v             <= (state == VERIFY) && !bram_ZYNQ_INST_en && bram_ZYNQ_INST_we;
      cmp_addr          <= bram_ZYNQ_INST_addr;

      case (state)
        IDLE, DONE, ERR: begin
          if (go) begin
            state      <= LOAD;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 3'b000;
            word_count <= '0;
            csum       <= '0;
            rb_sum     <= '0;
            verify_q   <= verify_en;
          end
        end

        LOAD: begin
          if (accept) begin
            bram_ZYNQ_INST_addr <= word_count[ADDR_WIDTH-1:0];
            bram_ZYNQ_INST_din  <= s_data;
            bram_ZYNQ_INST_en   <= 1'b0;
            bram_ZYNQ_INST_we   <= 1'b0;
            word_count          <= word_count + CNT_W'(1);
            csum                <= csum ^ s_data;
            if (s_last) begin
              s_ready <= 1'b0;
              rd_cnt  <= '0;
              state   <= verify_q ? VERIFY : ARM;
            end else if (last_slot) begin
              s_ready  <= 1'b0;
              error[0] <= 1'b1;
              busy     <= 1'b0;
              state    <= ERR;
            end
          end
        end

        VERIFY: begin
          if (rd_cnt < word_count) begin
            bram_ZYNQ_INST_addr <= rd_cnt[ADDR_WIDTH-1:0];
            bram_ZYNQ_INST_en   <= 1'b0;
            rd_cnt              <= rd_cnt + CNT_W'(1);
          end
          if (cmp_v) begin
            rb_sum <= rb_sum ^ bram_ZYNQ_INST_dout;
            if (bram_ZYNQ_INST_dout != exp_word) begin
              error[1]          <= 1'b1;
              err_addr          <= cmp_addr;
              bram_ZYNQ_INST_en <= 1'b1;
              busy              <= 1'b0;
              state             <= ERR;
            end else if (cmp_addr == ADDR_WIDTH'(word_count - CNT_W'(1))) begin
              if ((rb_sum ^ bram_ZYNQ_INST_dout) != csum) begin
                error[1] <= 1'b1;
                err_addr <= '1;
                busy     <= 1'b0;
                state    <= ERR;
              end else begin
                state <= ARM;
              end
            end
          end
        end

        // START only once the port has been idle for a full cycle.
        ARM: begin
          if (bram_ZYNQ_INST_en) begin
            START <= 1'b1;
            wd    <= '0;
            state <= WAIT_LO;
          end
        end

        WAIT_LO, WAIT_HI: begin
          wd <= wd_next;
          if (&wd_next) begin
            error[2] <= 1'b1;
            START    <= 1'b0;
            busy     <= 1'b0;
            state    <= ERR;
          end else if (state == WAIT_LO && !COMPLETED) begin
            state <= WAIT_HI;
          end else if (state == WAIT_HI && COMPLETED) begin
            START <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_program_loader.sv
// Self-checking bench for ctrl_program_loader with SRAM and tester models and a
// spec-level expectation of writes, reads, START latency and status flags.
module tb_ctrl_program_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 60;
  localparam int unsigned TW    = 6;
  localparam int unsigned DEPTH = 16;

  logic          CLK_100 = 1'b0;
  logic          RST = 1'b1;
  logic          go = 1'b0;
  logic          verify_en = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [CW-1:0] bram_din;
  logic [CW-1:0] bram_dout;
  logic          bram_en;
  logic          bram_we;
  logic          START;
  logic          COMPLETED = 1'b1;
  logic          busy;
  logic          done;
  logic [2:0]    error;
  logic [AW:0]   word_count;
  logic [AW-1:0] err_addr;

  int checks = 0;
  int passed = 0;

  ctrl_program_loader #(.ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
    .CLK_100(CLK_100), .RST(RST), .go(go), .verify_en(verify_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .bram_ZYNQ_INST_addr(bram_addr), .bram_ZYNQ_INST_din(bram_din),
    .bram_ZYNQ_INST_dout(bram_dout), .bram_ZYNQ_INST_en(bram_en),
    .bram_ZYNQ_INST_we(bram_we), .START(START), .COMPLETED(COMPLETED),
    .busy(busy), .done(done), .error(error), .word_count(word_count),
    .err_addr(err_addr)
  );

  always #5 CLK_100 = ~CLK_100;

  // SRAM model, optionally corrupting one address on readback.
  logic [CW-1:0] mem [DEPTH];
  int corrupt_addr = -1;
  always @(posedge CLK_100) begin
    if (!bram_en) begin
      if (!bram_we) mem[bram_addr] <= bram_din;
      else if (int'(bram_addr) == corrupt_addr) bram_dout <= mem[bram_addr] ^ CW'(1);
      else bram_dout <= mem[bram_addr];
    end
  end

  // Tester model: drops COMPLETED the cycle after START rises, holds it low run_len cycles.
  bit stuck = 1'b0;
  int run_len = 3;
  int tcnt = 0;
  bit ran = 1'b0;
  always @(posedge CLK_100) begin
    if (RST) begin
      COMPLETED <= 1'b1;
      ran       <= 1'b0;
      tcnt      <= 0;
    end else if (!stuck) begin
      if (START && COMPLETED && !ran) begin
        COMPLETED <= 1'b0;
        tcnt      <= run_len;
        ran       <= 1'b1;
      end else if (!COMPLETED) begin
        if (tcnt <= 1) COMPLETED <= 1'b1;
        else tcnt <= tcnt - 1;
      end else if (!START) begin
        ran <= 1'b0;
      end
    end
  end

  // Bus monitor.
  int cyc = 0;
  always @(posedge CLK_100) cyc <= cyc + 1;

  logic [AW-1:0] wr_a[$];
  logic [CW-1:0] wr_d[$];
  logic [AW-1:0] rd_a[$];
  bit start_seen = 1'b0;
  int start_cyc = 0;
  int start_hi = 0;
  int last_acc = 0;
  int excl_viol = 0;
  always @(negedge CLK_100) begin
    if (!RST) begin
      if (!bram_en && !bram_we) begin wr_a.push_back(bram_addr); wr_d.push_back(bram_din); end
      if (!bram_en && bram_we) rd_a.push_back(bram_addr);
      if (START && !start_seen) begin start_seen = 1'b1; start_cyc = cyc; end
      if (START) start_hi++;
      if (START && !bram_en) excl_viol++;
      if (s_valid && s_ready) last_acc = cyc + 1;
    end
  end

  logic [CW-1:0] words [64];

  task automatic tick();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic gen_words(input int n);
    for (int i = 0; i < n; i++) words[i] = CW'({$urandom, $urandom});
  endtask

  task automatic do_go(input bit ve);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    start_seen = 1'b0; start_hi = 0;
    go = 1'b1; verify_en = ve;
    tick();
    go = 1'b0; verify_en = 1'b0;
  endtask

  task automatic send_stream(input int n, input bit with_last, input int gap_pct, input int go_at);
    int guard;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin s_valid = 1'b0; tick(); end
      s_valid = 1'b1; s_data = words[i]; s_last = with_last && (i == n - 1);
      guard = 0;
      while (!s_ready && guard < 50) begin tick(); guard++; end
      if (guard >= 50) begin
        $display("FAIL stream_stall: beat %0d never accepted", i);
        checks++;
      end
      if (i == go_at) go = 1'b1;
      tick();
      go = 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int g = 0;
    while (!(done || error != 3'b000) && g < budget) begin tick(); g++; end
    checks++;
    if (g >= budget) $display("FAIL wait_end: no done/error within %0d cycles", budget);
    else passed++;
    tick();
  endtask

  // Expected-writes comparison: address i holds word i, for exactly n writes.
  task automatic check_writes(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= wr_a.size() || int'(wr_a[i]) != i || wr_d[i] !== words[i]) bad++;
    checks++;
    if (wr_a.size() != n || bad != 0)
      $display("FAIL %s_writes: got %0d writes (%0d bad) expected %0d", tag, wr_a.size(), bad, n);
    else passed++;
  endtask

  task automatic check_reads(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n && i < rd_a.size(); i++) if (int'(rd_a[i]) != i) bad++;
    checks++;
    if (rd_a.size() != n || bad != 0)
      $display("FAIL %s_reads: got %0d reads (%0d bad) expected %0d", tag, rd_a.size(), bad, n);
    else passed++;
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    checks++;
    if ({s_ready, START, busy, done, error} !== 7'b0) $display("FAIL reset_ctrl: got %b expected 0", {s_ready, START, busy, done, error});
    else passed++;
    checks++;
    if ({bram_en, bram_we} !== 2'b11) $display("FAIL reset_port: got en/we %b expected 11", {bram_en, bram_we});
    else passed++;
    checks++;
    if (bram_addr !== '0 || bram_din !== '0) $display("FAIL reset_bus: got addr %0h din %0h expected 0", bram_addr, bram_din);
    else passed++;
    checks++;
    if (word_count !== '0 || err_addr !== '0) $display("FAIL reset_counts: got wc %0d err_addr %0d expected 0", word_count, err_addr);
    else passed++;
  endtask

  task automatic test_basic_load();
    gen_words(5);
    words[4][0] = 1'b1;
    run_len = 2;
    do_go(1'b0);
    send_stream(5, 1'b1, 0, -1);
    wait_end(100);
    check_writes("basic", 5);
    check_reads("basic", 0);
    checks++;
    if (start_cyc - last_acc != 2) $display("FAIL basic_start_latency: got %0d expected 2", start_cyc - last_acc);
    else passed++;
    checks++;
    if (done !== 1'b1 || error !== 3'b000 || busy !== 1'b0) $display("FAIL basic_status: got done %b error %b busy %b expected 1 000 0", done, error, busy);
    else passed++;
    checks++;
    if (word_count !== 5'd5) $display("FAIL basic_word_count: got %0d expected 5", word_count);
    else passed++;
  endtask

  task automatic test_verify_backpressure();
    gen_words(8);
    run_len = $urandom_range(1, 5);
    do_go(1'b1);
    send_stream(8, 1'b1, 40, -1);
    wait_end(200);
    check_writes("verify", 8);
    check_reads("verify", 8);
    checks++;
    if (start_cyc - last_acc != 11) $display("FAIL verify_start_latency: got %0d expected 11", start_cyc - last_acc);
    else passed++;
    checks++;
    if (done !== 1'b1 || error !== 3'b000) $display("FAIL verify_status: got done %b error %b expected 1 000", done, error);
    else passed++;
  endtask

  task automatic test_verify_mismatch();
    int bad = 0;
    gen_words(6);
    corrupt_addr = 3;
    do_go(1'b1);
    send_stream(6, 1'b1, 0, -1);
    wait_end(200);
    tick(); tick();
    corrupt_addr = -1;
    checks++;
    if (error !== 3'b010 || done !== 1'b0) $display("FAIL mismatch_error: got error %b done %b expected 010 0", error, done);
    else passed++;
    checks++;
    if (err_addr !== 4'd3) $display("FAIL mismatch_err_addr: got %0d expected 3", err_addr);
    else passed++;
    checks++;
    if (start_seen) $display("FAIL mismatch_start: got START asserted expected never");
    else passed++;
    for (int i = 0; i < 4; i++) if (i >= rd_a.size() || int'(rd_a[i]) != i) bad++;
    checks++;
    if (bad != 0 || rd_a.size() > 6) $display("FAIL mismatch_reads: got %0d reads (%0d bad) expected 0..3 first", rd_a.size(), bad);
    else passed++;
  endtask

  task automatic test_overflow();
    gen_words(16);
    do_go(1'b0);
    send_stream(16, 1'b0, 20, -1);
    checks++;
    if (s_ready !== 1'b0 || word_count !== 5'd16) $display("FAIL overflow_ready: got s_ready %b wc %0d expected 0 16", s_ready, word_count);
    else passed++;
    tick(); tick();
    checks++;
    if (error !== 3'b001 || busy !== 1'b0 || start_seen) $display("FAIL overflow_error: got error %b busy %b start %b expected 001 0 0", error, busy, start_seen);
    else passed++;
    check_writes("overflow", 16);
  endtask

  task automatic test_timeout();
    gen_words(3);
    stuck = 1'b1;
    do_go(1'b0);
    send_stream(3, 1'b1, 0, -1);
    wait_end(300);
    stuck = 1'b0;
    checks++;
    if (error !== 3'b100 || done !== 1'b0) $display("FAIL timeout_error: got error %b done %b expected 100 0", error, done);
    else passed++;
    checks++;
    if (start_hi != 63 || START !== 1'b0) $display("FAIL timeout_start: got %0d START cycles, START now %b expected 63 0", start_hi, START);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    int g = 0;
    int n;
    gen_words(4);
    run_len = 30;
    do_go(1'b0);
    send_stream(4, 1'b1, 0, -1);
    while (!(START && !COMPLETED) && g < 100) begin tick(); g++; end
    checks++;
    if (g >= 100) $display("FAIL midrun_reach_wait: START/COMPLETED handshake not reached");
    else passed++;
    tick(); tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({START, busy, bram_en, bram_we, s_ready} !== 5'b00110) $display("FAIL midrun_reset: got START/busy/en/we/ready %b expected 00110", {START, busy, bram_en, bram_we, s_ready});
    else passed++;
    checks++;
    if (word_count !== '0 || done !== 1'b0 || error !== 3'b000) $display("FAIL midrun_flags: got wc %0d done %b error %b expected 0 0 000", word_count, done, error);
    else passed++;
    RST = 1'b0;
    tick();
    n = $urandom_range(2, 9);
    gen_words(n);
    run_len = 2;
    do_go(1'($urandom_range(1)));
    send_stream(n, 1'b1, 10, -1);
    wait_end(200);
    checks++;
    if (done !== 1'b1 || error !== 3'b000 || word_count !== 5'(n)) $display("FAIL midrun_rerun: got done %b error %b wc %0d expected 1 000 %0d", done, error, word_count, n);
    else passed++;
    check_writes("midrun", n);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(1, 12);
      bit ve = 1'($urandom_range(1));
      int exp_lat = ve ? n + 3 : 2;
      gen_words(n);
      run_len = $urandom_range(1, 6);
      do_go(ve);
      send_stream(n, 1'b1, 25, (n > 1) ? 1 : -1);
      wait_end(200);
      check_writes("b2b", n);
      check_reads("b2b", ve ? n : 0);
      checks++;
      if (start_cyc - last_acc != exp_lat) $display("FAIL b2b_start_latency: got %0d expected %0d (n %0d verify %0d)", start_cyc - last_acc, exp_lat, n, ve);
      else passed++;
      checks++;
      if (done !== 1'b1 || error !== 3'b000 || word_count !== 5'(n)) $display("FAIL b2b_status: got done %b error %b wc %0d expected 1 000 %0d", done, error, word_count, n);
      else passed++;
    end
  endtask

  task automatic test_port_exclusive();
    checks++;
    if (excl_viol != 0) $display("FAIL port_exclusive: got %0d cycles with START and en low expected 0", excl_viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_verify_backpressure();
    test_verify_mismatch();
    test_overflow();
    test_timeout();
    test_reset_midrun();
    test_back_to_back();
    test_port_exclusive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
